// File: rtl/serial_link_pkg.sv
// Shared definitions for the single-bit sample link between the FIR and its
// sample sources. The transmitter (serial_word_tx) and the matching receiver
// both import this package.
//   tx_state_t          transmitter FSM encoding
//   DEFAULT_DATA_WIDTH  word width used by the FIR datapath
//   cnt_w(n)            width of a counter that must reach n-1 (minimum 1 bit)
package serial_link_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    GAP
  } tx_state_t;

  localparam int DEFAULT_DATA_WIDTH = 24;

  // A counter that runs 0..n-1 needs $clog2(n) bits. A zero-width vector is
  // not legal, so n<=1 still gets a single bit.
  function automatic int cnt_w(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage : serial_link_pkg

// File: rtl/serial_word_tx.sv
// Parallel-to-serial transmitter for the FIR's single-bit sample link.
// Each DATA_WIDTH word is shifted out LSB first, one bit per enabled cycle.
// A one-word holding register is refilled while the shifter is busy, so with
// MIN_GAP=0 consecutive words stream with no idle bubble.
//
// Ports
//   i_clk         single clock, rising edge
//   i_rst         synchronous, active-high reset
//   i_en          clock enable shared with the downstream receiver
//   i_word        parallel word to transmit
//   i_word_valid  i_word is offered
//   o_word_ready  word accepted on an edge where i_word_valid && o_word_ready
//   o_dout        serial data, LSB first (registered, 0 when idle)
//   o_dout_valid  high only while o_dout carries bit DATA_WIDTH-1 (registered)
//   o_busy        transmitter not idle, or holding register full
module serial_word_tx
  import serial_link_pkg::*;
#(
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int MIN_GAP    = 0
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_en,
  input  logic [DATA_WIDTH-1:0] i_word,
  input  logic                  i_word_valid,
  output logic                  o_word_ready,
  output logic                  o_dout,
  output logic                  o_dout_valid,
  output logic                  o_busy
);

  localparam int BW = cnt_w(DATA_WIDTH);
  localparam int GW = cnt_w(MIN_GAP + 1);

  localparam logic [BW-1:0] LAST_BIT = BW'(DATA_WIDTH - 1);
  localparam logic [BW-1:0] PRE_LAST = BW'(DATA_WIDTH - 2);
  localparam logic [GW-1:0] LAST_GAP = GW'((MIN_GAP > 0) ? MIN_GAP - 1 : 0);

  if (DATA_WIDTH < 2) begin : g_bad_width
    $error("serial_word_tx: DATA_WIDTH must be >= 2");
  end

  tx_state_t             state_q, state_d;
  logic [DATA_WIDTH-1:0] shift_q, shift_d;
  logic [BW-1:0]         bit_cnt_q, bit_cnt_d;
  logic [GW-1:0]         gap_cnt_q, gap_cnt_d;
  logic                  dout_q, dout_d;
  logic                  dout_valid_q, dout_valid_d;
  logic [DATA_WIDTH-1:0] hold_reg_q;
  logic                  hold_full_q;
  logic                  accept;
  logic                  load;

  // Ready must drop during reset even though hold_full is only cleared on
  // the reset edge itself.
  assign o_word_ready = !hold_full_q && !i_rst;
  assign accept       = i_word_valid && o_word_ready;

  // Next-state and datapath decode. With i_en low every register holds,
  // except the valid pulse, which only lives for one enabled cycle.
  always_comb begin
    // NOTE: every signal gets a default before the case so no path leaves it
    // unassigned; a missing default here would infer a latch.
    state_d      = state_q;
    shift_d      = shift_q;
    bit_cnt_d    = bit_cnt_q;
    gap_cnt_d    = gap_cnt_q;
    dout_d       = dout_q;
    dout_valid_d = 1'b0;
    load         = 1'b0;

    if (i_en) begin
      unique case (state_q)
        IDLE: begin
          load = hold_full_q;
        end

        SHIFT: begin
          if (bit_cnt_q == LAST_BIT) begin
            if (MIN_GAP > 0) begin
              state_d   = GAP;
              gap_cnt_d = '0;
              dout_d    = 1'b0;
            end else if (hold_full_q) begin
              load = 1'b1;
            end else begin
              state_d = IDLE;
              dout_d  = 1'b0;
            end
          end else begin
            // o_dout always shows bit 0 of the post-shift register, so the
            // next bit is taken from shift_q[1] on the same edge.
            shift_d      = shift_q >> 1;
            dout_d       = shift_q[1];
            bit_cnt_d    = bit_cnt_q + BW'(1);
            dout_valid_d = (bit_cnt_q == PRE_LAST);
          end
        end

        GAP: begin
          if (gap_cnt_q == LAST_GAP) begin
            if (hold_full_q) begin
              load = 1'b1;
            end else begin
              state_d = IDLE;
            end
          end else begin
            gap_cnt_d = gap_cnt_q + GW'(1);
          end
        end

        default: begin
          state_d = IDLE;
          dout_d  = 1'b0;
        end
      endcase

      if (load) begin
        state_d   = SHIFT;
        shift_d   = hold_reg_q;
        bit_cnt_d = '0;
        dout_d    = hold_reg_q[0];
      end
    end
  end

  always_ff @(posedge i_clk) begin
    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values regardless of statement order.
    if (i_rst) begin
      state_q      <= IDLE;
      shift_q      <= '0;
      bit_cnt_q    <= '0;
      gap_cnt_q    <= '0;
      dout_q       <= 1'b0;
      dout_valid_q <= 1'b0;
      hold_full_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      shift_q      <= shift_d;
      bit_cnt_q    <= bit_cnt_d;
      gap_cnt_q    <= gap_cnt_d;
      dout_q       <= dout_d;
      dout_valid_q <= dout_valid_d;
      // Load and accept never coincide: ready is low whenever hold is full.
      if (load) begin
        hold_full_q <= 1'b0;
      end else if (accept) begin
        hold_full_q <= 1'b1;
      end
    end
  end

  // NOTE: the holding data register has no reset; hold_full_q qualifies it,
  // so its contents are never observed before a word has been written.
  always_ff @(posedge i_clk) begin
    if (accept) begin
      hold_reg_q <= i_word;
    end
  end

  assign o_dout       = dout_q;
  assign o_dout_valid = dout_valid_q;
  assign o_busy       = (state_q != IDLE) || hold_full_q;

endmodule : serial_word_tx
